// File: rtl/spm_bank_scheduler.sv
// spm_bank_scheduler: round-robin sharing of interleaved latency-1 SPM banks, with a zero-fill sequencer.
module spm_bank_scheduler #(
  parameter int NumReq       = 2,
  parameter int NumBanks     = 4,
  parameter int WordsPerBank = 1024,
  parameter int DataWidth    = 64,
  parameter int AddrWidth    = 18,
  parameter bit InitOnReset  = 1'b1,
  localparam int IW = $clog2(WordsPerBank),
  localparam int SW = DataWidth / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clear_i,
  input  logic [NumReq-1:0]                    req_i,
  output logic [NumReq-1:0]                    gnt_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumReq-1:0][SW-1:0]            strb_i,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [NumReq-1:0][DataWidth-1:0]     rdata_o,
  output logic [NumBanks-1:0]                  bank_req_o,
  output logic [NumBanks-1:0]                  bank_we_o,
  output logic [NumBanks-1:0][IW-1:0]          bank_addr_o,
  output logic [NumBanks-1:0][DataWidth-1:0]   bank_wdata_o,
  output logic [NumBanks-1:0][SW-1:0]          bank_be_o,
  input  logic [NumBanks-1:0][DataWidth-1:0]   bank_rdata_i,
  output logic                                 init_done_o
);
  localparam int Off = $clog2(SW);
  localparam int LB  = $clog2(NumBanks);
  localparam int BW  = LB > 0 ? LB : 1;
  localparam int RW  = NumReq > 1 ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {INIT, READY, DRAIN} state_e;

  state_e                          state_q;
  logic                            init_done_q;
  logic [IW-1:0]                   cnt_q;
  logic [NumBanks-1:0][RW-1:0]     rr_q, rr_d;
  logic [NumReq-1:0]               rvalid_q;
  logic [NumReq-1:0][BW-1:0]       rbank_q;
  logic [NumReq-1:0][BW-1:0]       bank_sel;
  logic [NumReq-1:0][IW-1:0]       idx;
  logic [NumBanks-1:0]             bgnt;
  logic [NumBanks-1:0][RW-1:0]     win;
  logic [NumReq-1:0]               gnt;

  always_comb begin
    for (int r = 0; r < NumReq; r++) begin
      bank_sel[r] = NumBanks == 1 ? '0 : BW'(addr_i[r] >> Off);
      idx[r]      = IW'(addr_i[r] >> (Off + LB));
    end
  end

  // Scan downward from the pointer so the closest candidate is assigned last and wins.
  always_comb begin
    bgnt = '0;
    win  = '0;
    gnt  = '0;
    rr_d = rr_q;
    for (int b = 0; b < NumBanks; b++) begin
      for (int k = NumReq - 1; k >= 0; k--) begin
        if (state_q == READY && req_i[(int'(rr_q[b]) + k) % NumReq] &&
            bank_sel[(int'(rr_q[b]) + k) % NumReq] == BW'(b)) begin
          bgnt[b] = 1'b1;
          win[b]  = RW'((int'(rr_q[b]) + k) % NumReq);
        end
      end
      if (bgnt[b]) begin
        gnt[win[b]] = 1'b1;
        rr_d[b]     = RW'((int'(win[b]) + 1) % NumReq);
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NumBanks; b++) begin
      bank_req_o[b]   = !rst_i && (state_q == INIT || bgnt[b]);
      bank_we_o[b]    = state_q == INIT || (bgnt[b] && we_i[win[b]]);
      bank_addr_o[b]  = state_q == INIT ? cnt_q : idx[win[b]];
      bank_wdata_o[b] = state_q == INIT ? '0 : wdata_i[win[b]];
      bank_be_o[b]    = state_q == INIT ? '1 : strb_i[win[b]];
    end
    for (int r = 0; r < NumReq; r++) rdata_o[r] = rvalid_q[r] ? bank_rdata_i[rbank_q[r]] : '0;
  end

  assign gnt_o       = gnt;
  assign rvalid_o    = rvalid_q;
  assign init_done_o = init_done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= InitOnReset ? INIT : READY;
      init_done_q <= !InitOnReset;
      cnt_q       <= '0;
      rr_q        <= '0;
      rvalid_q    <= '0;
      rbank_q     <= '0;
    end else begin
      rr_q     <= rr_d;
      rvalid_q <= gnt;
      for (int r = 0; r < NumReq; r++) if (gnt[r]) rbank_q[r] <= bank_sel[r];
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IW'(WordsPerBank - 1)) begin
            state_q     <= READY;
            init_done_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        READY: begin
          if (clear_i) begin
            state_q     <= DRAIN;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= INIT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spm_bank_scheduler.sv
// tb_spm_bank_scheduler: directed stimulus with a per-requester response scoreboard and a behavioural SRAM array.
module tb_spm_bank_scheduler;
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  clear_i = 1'b0;
  logic [1:0]            req_i = '0;
  logic [1:0]            gnt_o;
  logic [1:0][17:0]      addr_i = '0;
  logic [1:0]            we_i = '0;
  logic [1:0][63:0]      wdata_i = '0;
  logic [1:0][7:0]       strb_i = '0;
  logic [1:0]            rvalid_o;
  logic [1:0][63:0]      rdata_o;
  logic [3:0]            bank_req_o;
  logic [3:0]            bank_we_o;
  logic [3:0][9:0]       bank_addr_o;
  logic [3:0][63:0]      bank_wdata_o;
  logic [3:0][7:0]       bank_be_o;
  logic [3:0][63:0]      bank_rdata_i = '0;
  logic                  init_done_o;

  spm_bank_scheduler dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_i), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .strb_i(strb_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .bank_req_o(bank_req_o), .bank_we_o(bank_we_o),
    .bank_addr_o(bank_addr_o), .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o),
    .bank_rdata_i(bank_rdata_i), .init_done_o(init_done_o)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [4][1024];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_req_o[b]) begin
        if (bank_we_o[b]) begin
          for (int j = 0; j < 8; j++)
            if (bank_be_o[b][j]) mem[b][bank_addr_o[b]][j*8 +: 8] <= bank_wdata_o[b][j*8 +: 8];
        end else bank_rdata_i[b] <= mem[b][bank_addr_o[b]];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic wr; logic [63:0] d; int c;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input int r);
    exp_t e;
    if ((r == 0 ? q0.size() : q1.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL rvalid_unexpected r%0d: got rvalid=1 expected no response (cycle %0d)", r, cyc);
    end else begin
      e = r == 0 ? q0.pop_front() : q1.pop_front();
      chk($sformatf("rvalid_latency r%0d", r), 64'(cyc), 64'(e.c));
      if (!e.wr) chk($sformatf("rdata r%0d", r), rdata_o[r], e.d);
    end
  endtask

  always @(negedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (rvalid_o[r]) pop_cmp(r);
      else chk($sformatf("rdata_idle r%0d", r), rdata_o[r], 64'h0);
    end
  end

  task automatic drive(input logic clr, input logic [1:0] req, input logic [1:0] we,
                       input logic [17:0] a0, input logic [17:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic [7:0] s0, input logic [7:0] s1,
                       input logic [1:0] eg, input logic [3:0] eb,
                       input logic [63:0] e0, input logic [63:0] e1);
    clear_i = clr; req_i = req; we_i = we;
    addr_i[0] = a0; addr_i[1] = a1; wdata_i[0] = d0; wdata_i[1] = d1; strb_i[0] = s0; strb_i[1] = s1;
    #1;
    chk("gnt", 64'(gnt_o), 64'(eg));
    chk("bank_req", 64'(bank_req_o), 64'(eb));
    if (eg[0]) q0.push_back('{we[0], e0, cyc + 1});
    if (eg[1]) q1.push_back('{we[1], e1, cyc + 1});
    @(negedge clk);
    clear_i = 1'b0; req_i = '0; we_i = '0;
  endtask

  task automatic init_check(input string n);
    int bad = 0;
    req_i = 2'b11; we_i = 2'b00; addr_i[0] = 18'h20; addr_i[1] = 18'h48; clear_i = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      #1;
      if (bank_req_o !== 4'hF || bank_we_o !== 4'hF || gnt_o !== 2'b00 || init_done_o !== 1'b0) bad++;
      for (int b = 0; b < 4; b++)
        if (bank_be_o[b] !== 8'hFF || bank_wdata_o[b] !== 64'h0 || bank_addr_o[b] !== 10'(i)) bad++;
      @(negedge clk);
    end
    req_i = '0; clear_i = 1'b0;
    chk({n, "_fill_errors"}, 64'(bad), 64'h0);
    #1;
    chk({n, "_init_done"}, 64'(init_done_o), 64'h1);
    @(negedge clk);
  endtask

  initial begin
    req_i = 2'b11; addr_i[0] = 18'h0; addr_i[1] = 18'h18;
    @(negedge clk);
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_rvalid", 64'(rvalid_o), 64'h0);
    chk("rst_rdata", 64'(rdata_o[0] | rdata_o[1]), 64'h0);
    chk("rst_bank_req", 64'(bank_req_o), 64'h0);
    chk("rst_init_done", 64'(init_done_o), 64'h0);
    rst = 1'b0;
    init_check("init1");

    drive(0, 2'b01, 2'b01, 18'h20, 18'h0, 64'hDEADBEEF_CAFEF00D, 64'h0, 8'hFF, 8'h00, 2'b01, 4'b0001, 64'h0, 64'h0);
    drive(0, 2'b01, 2'b00, 18'h20, 18'h0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01, 4'b0001, 64'hDEADBEEF_CAFEF00D, 64'h0);
    drive(0, 2'b01, 2'b01, 18'h08, 18'h0, 64'h1111_1111_1111_1111, 64'h0, 8'hFF, 8'h00, 2'b01, 4'b0010, 64'h0, 64'h0);
    drive(0, 2'b10, 2'b10, 18'h0, 18'h48, 64'h0, 64'h2222_2222_2222_2222, 8'h00, 8'h0F, 2'b10, 4'b0010, 64'h0, 64'h0);
    drive(0, 2'b10, 2'b10, 18'h0, 18'h18, 64'h0, 64'h3333_4444_5555_6666, 8'h00, 8'hFF, 2'b10, 4'b1000, 64'h0, 64'h0);
    for (int i = 0; i < 4; i++)
      drive(0, 2'b11, 2'b00, 18'h08, 18'h48, 64'h0, 64'h0, 8'h00, 8'h00, i % 2 == 0 ? 2'b01 : 2'b10, 4'b0010,
            64'h1111_1111_1111_1111, 64'h0000_0000_2222_2222);
    drive(0, 2'b11, 2'b00, 18'h00, 18'h18, 64'h0, 64'h0, 8'h00, 8'h00, 2'b11, 4'b1001, 64'h0, 64'h3333_4444_5555_6666);
    drive(0, 2'b11, 2'b00, 18'h20, 18'h8020, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10, 4'b0001, 64'h0, 64'hDEADBEEF_CAFEF00D);
    drive(0, 2'b01, 2'b00, 18'h20, 18'h0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01, 4'b0001, 64'hDEADBEEF_CAFEF00D, 64'h0);

    chk("ready_init_done", 64'(init_done_o), 64'h1);
    drive(1, 2'b01, 2'b00, 18'h20, 18'h0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01, 4'b0001, 64'hDEADBEEF_CAFEF00D, 64'h0);
    chk("drain_init_done", 64'(init_done_o), 64'h0);
    drive(1, 2'b01, 2'b00, 18'h20, 18'h0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b00, 4'b0000, 64'h0, 64'h0);
    init_check("clear");
    drive(0, 2'b01, 2'b00, 18'h20, 18'h0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01, 4'b0001, 64'h0, 64'h0);

    drive(1, 2'b00, 2'b00, 18'h0, 18'h0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b00, 4'b0000, 64'h0, 64'h0);
    drive(0, 2'b00, 2'b00, 18'h0, 18'h0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b00, 4'b0000, 64'h0, 64'h0);
    repeat (500) @(negedge clk);
    #1;
    chk("mid_init_addr", 64'(bank_addr_o[0]), 64'd500);
    rst = 1'b1;
    #1;
    chk("mid_init_rst_bank_req", 64'(bank_req_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    init_check("restart");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q0.size() + q1.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
